bus_generator_arbiter: RTL and testbench

//  Shared-bus generator and arbiter joining drvrs devices on each of bits independent buses.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_channel.sv | 121 ++++++++++++
 rtl/bus_generator_arbiter.sv | 51 +++++
 tb/tb_bus_generator_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus generator/arbiter.
//   ID_W      : width of the destination ID field (top byte of every packet)
//   BROADCAST : destination ID that delivers to every device except the source
//   bus_state_e : per-bus FSM state (IDLE waits for a pending device,
//                 DELIVER is the single pop cycle before the push)
package bus_pkg;

    localparam int              ID_W      = 8;
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    typedef enum logic {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } bus_state_e;

endpackage : bus_pkg

// File: rtl/bus_channel.sv
// One bus: round-robin arbiter, two-state FSM and destination decode.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   pndng_i  : per-device FIFO non-empty
//   d_pop_i  : per-device FIFO head word
//   pop_o    : one-cycle pop strobe to the granted device (registered)
//   push_o   : one-cycle push strobe to the destination device(s) (registered)
//   d_push_o : delivered word, replicated on every device slot
//   state_o  : current FSM state, exported for observation
//
// Handshake: pndng_i acts as valid and pop_o as the ready/accept strobe. A
// device seen pending at edge N gets pop_o during cycle N+1 and its head word
// is sampled at the end of that cycle; push_o/d_push_o are high in cycle N+2.
module bus_channel
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng_i,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop_i,
    output logic [drvrs-1:0]                 pop_o,
    output logic [drvrs-1:0]                 push_o,
    output logic [drvrs-1:0][pckg_sz-1:0]    d_push_o,
    output bus_state_e                       state_o
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    bus_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;       // last granted device
    logic [IDX_W-1:0]   src_q, src_d;     // device being popped this cycle
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [pckg_sz-1:0] word_q, word_d;   // last delivered word

    logic               found;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   cand;
    logic [pckg_sz-1:0] head;
    logic [ID_W-1:0]    dest;

    // Round-robin search: scan starting one past the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < drvrs; k++) begin
            cand = IDX_W'((int'(rr_q) + 1 + k) % drvrs);
            if (!found && pndng_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // The head of the popped device is taken during the pop cycle itself,
    // so a pndng drop after the grant does not cancel the transfer.
    assign head = d_pop_i[src_q];
    assign dest = head[pckg_sz-1 -: ID_W];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        pop_d   = '0;
        push_d  = '0;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    pop_d[grant] = 1'b1;
                    src_d        = grant;
                    rr_d         = grant;
                    state_d      = DELIVER;
                end
            end
            DELIVER: begin
                word_d = head;
                // An ID that is neither a device index nor broadcast matches
                // no slot, which drops the packet.
                for (int i = 0; i < drvrs; i++) begin
                    push_d[i] = (dest == ID_W'(i)) ||
                                ((dest == broadcast) && (src_q != IDX_W'(i)));
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= IDX_W'(drvrs - 1);
            src_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            word_q  <= word_d;
        end
    end

    assign pop_o   = pop_q;
    assign push_o  = push_q;
    assign state_o = state_q;

    for (genvar i = 0; i < drvrs; i++) begin : g_dpush
        assign d_push_o[i] = word_q;
    end

endmodule : bus_channel

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator and arbiter: bits independent buses, each joining
// drvrs devices. Every bus round-robin pops one pending device and pushes the
// packet to the device(s) named by its top byte.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   pndng     : [bits][drvrs] device FIFO non-empty
//   D_pop     : [bits][drvrs][pckg_sz] device FIFO head words
//   pop       : [bits][drvrs] one-cycle pop strobes
//   push      : [bits][drvrs] one-cycle push strobes
//   D_push    : [bits][drvrs][pckg_sz] delivered word per bus
//   state_dbg : [bits] 1 while the bus FSM is in DELIVER
module bus_generator_arbiter
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push,
    output logic [bits-1:0]                          state_dbg
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_state_e ch_state;

        bus_channel #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_channel (
            .clk      (clk),
            .reset    (reset),
            .pndng_i  (pndng[b]),
            .d_pop_i  (D_pop[b]),
            .pop_o    (pop[b]),
            .push_o   (push[b]),
            .d_push_o (D_push[b]),
            .state_o  (ch_state)
        );

        assign state_dbg[b] = (ch_state == DELIVER);
    end

endmodule : bus_generator_arbiter

// File: tb/tb_bus_generator_arbiter.sv
module tb_bus_generator_arbiter;

    localparam int BITS  = 2;
    localparam int DRVRS = 4;
    localparam int PSZ   = 16;

    logic                                 clk = 1'b0;
    logic                                 reset;
    logic [BITS-1:0][DRVRS-1:0]           pndng;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]  D_pop;
    logic [BITS-1:0][DRVRS-1:0]           pop;
    logic [BITS-1:0][DRVRS-1:0]           push;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]  D_push;
    logic [BITS-1:0]                      state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PSZ-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    bus_generator_arbiter #(
        .bits    (BITS),
        .drvrs   (DRVRS),
        .pckg_sz (PSZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .pop       (pop),
        .push      (push),
        .D_push    (D_push),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // pop/push vectors are {bus1, bus0}, 4 bits each
    task automatic check_strobes(input string tag, input logic [7:0] pop_e, input logic [7:0] push_e);
        check({tag, "_pop"}, 32'(pop), 32'(pop_e));
        check({tag, "_push"}, 32'(push), 32'(push_e));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dev(input int b, input int d, input logic [PSZ-1:0] w);
        pndng[b][d] = 1'b1;
        D_pop[b][d] = w;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]     rr_pop [5];
    logic [7:0]     rr_push[5];
    logic [PSZ-1:0] dexp;

    initial begin
        rr_pop  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
        rr_push = '{8'h02, 8'h04, 8'h08, 8'h01, 8'h02};

        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        repeat (2) step();
        check_strobes("reset", 8'h00, 8'h00);
        check("reset_dpush", 32'(D_push[0][0]), 32'h0);
        check("reset_state", 32'(state_dbg), 32'h0);

        // One delivery from dev1 so D_push holds a nonzero word
        reset = 1'b1;
        set_dev(0, 1, 16'h02AA);
        step();
        check_strobes("pre_pop", 8'h02, 8'h00);
        check("pre_state", 32'(state_dbg), 32'h1);
        pndng = '0;
        step();
        check_strobes("pre_push", 8'h00, 8'h04);
        check("pre_dpush", 32'(D_push[0][0]), 32'h02AA);

        // Grant dev2 (pointer now 2), then reset during its DELIVER cycle
        set_dev(0, 2, 16'h03BB);
        step();
        check_strobes("mid_pop", 8'h04, 8'h00);
        check("mid_state", 32'(state_dbg), 32'h1);
        reset = 1'b0;
        #1;
        check_strobes("async_rst", 8'h00, 8'h00);
        check("async_rst_dpush", 32'(D_push[0][0]), 32'h0);
        check("async_rst_state", 32'(state_dbg), 32'h0);

        // Release with all four pending: order must restart at dev0
        reset = 1'b1;
        pndng = '0;
        set_dev(0, 0, 16'h0100);
        set_dev(0, 1, 16'h0211);
        set_dev(0, 2, 16'h0322);
        set_dev(0, 3, 16'h0033);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0211);
        exp_q.push_back(16'h0322);
        exp_q.push_back(16'h0033);
        exp_q.push_back(16'h0100);
        for (int i = 0; i < 5; i++) begin
            step();
            check_strobes($sformatf("rr%0d_grant", i), rr_pop[i], 8'h00);
            step();
            check_strobes($sformatf("rr%0d_deliver", i), 8'h00, rr_push[i]);
            dexp = exp_q.pop_front();
            check($sformatf("rr%0d_dpush", i), 32'(D_push[0][0]), 32'(dexp));
        end
        pndng = '0;
        step();
        check_strobes("rr_drain", 8'h00, 8'h00);
        check("rr_drain_state", 32'(state_dbg), 32'h0);

        // Unicast dev2 -> dev1
        set_dev(0, 2, 16'h01AB);
        step();
        check_strobes("uni_pop", 8'h04, 8'h00);
        pndng = '0;
        step();
        check_strobes("uni_push", 8'h00, 8'h02);
        check("uni_dpush", 32'(D_push[0][0]), 32'h01AB);
        check("uni_dpush_slot3", 32'(D_push[0][3]), 32'h01AB);
        step();
        check_strobes("uni_after", 8'h00, 8'h00);
        check("uni_hold", 32'(D_push[0][0]), 32'h01AB);

        // Broadcast from dev0 -> devs 1,2,3
        set_dev(0, 0, 16'hFF55);
        step();
        check_strobes("bc_pop", 8'h01, 8'h00);
        pndng = '0;
        step();
        check_strobes("bc_push", 8'h00, 8'h0E);
        check("bc_dpush", 32'(D_push[0][0]), 32'hFF55);
        step();
        check_strobes("bc_after", 8'h00, 8'h00);

        // Invalid destination from dev3: popped, dropped
        set_dev(0, 3, 16'h07CD);
        step();
        check_strobes("bad_pop", 8'h08, 8'h00);
        check("bad_state_deliver", 32'(state_dbg), 32'h1);
        pndng = '0;
        step();
        check_strobes("bad_drop", 8'h00, 8'h00);
        check("bad_state_idle", 32'(state_dbg), 32'h0);

        // Self-addressed packet from dev2
        set_dev(0, 2, 16'h02EE);
        step();
        check_strobes("self_pop", 8'h04, 8'h00);
        pndng = '0;
        step();
        check_strobes("self_push", 8'h00, 8'h04);
        check("self_dpush", 32'(D_push[0][0]), 32'h02EE);

        // Two buses at once: bus0 dev1 -> dev3, bus1 dev2 -> dev0
        set_dev(0, 1, 16'h0312);
        set_dev(1, 2, 16'h0045);
        step();
        check_strobes("dual_pop", 8'h42, 8'h00);
        check("dual_state", 32'(state_dbg), 32'h3);
        pndng = '0;
        step();
        check_strobes("dual_push", 8'h00, 8'h18);
        check("dual_dpush0", 32'(D_push[0][0]), 32'h0312);
        check("dual_dpush1", 32'(D_push[1][3]), 32'h0045);

        // Broadcast on bus1 only: bus0 stays silent
        set_dev(1, 1, 16'hFF77);
        step();
        check_strobes("bus1_bc_pop", 8'h20, 8'h00);
        pndng = '0;
        step();
        check_strobes("bus1_bc_push", 8'h00, 8'hD0);
        check("bus1_bc_dpush", 32'(D_push[1][0]), 32'hFF77);
        check("bus0_hold", 32'(D_push[0][0]), 32'h0312);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bus_generator_arbiter
